// File: rtl/puf_dual_arbiter.sv
// puf_dual_arbiter: round-robin sharing of one PUF mapping engine between two requesters.
// Optional WAIT-state timeout abort is enabled by defining PUF_ARB_TIMEOUT_EN.
module puf_dual_arbiter #(
    parameter int IN_WIDTH  = 128,
    parameter int OUT_WIDTH = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [IN_WIDTH-1:0]  chal0,
    input  logic [IN_WIDTH-1:0]  chal1,
    output logic                 busy0,
    output logic                 busy1,
    output logic                 done0,
    output logic                 done1,
    output logic [OUT_WIDTH-1:0] resp0,
    output logic [OUT_WIDTH-1:0] resp1,
    output logic                 err0,
    output logic                 err1,
    output logic                 map_trigger,
    output logic [IN_WIDTH-1:0]  map_data,
    input  logic                 map_done,
    input  logic [OUT_WIDTH-1:0] map_resp
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;
    state_t               r_state, w_next;
    logic                 r_owner, r_last;
    logic [1:0]           r_pend;
    logic [IN_WIDTH-1:0]  r_hold0, r_hold1, r_map_data;
    logic [OUT_WIDTH-1:0] r_resp0, r_resp1;
    logic                 r_done0, r_done1, r_err0, r_err1;
    logic                 w_serving, w_cap0, w_cap1, w_grant_en, w_grant, w_tout, w_fin;
    logic [OUT_WIDTH-1:0] w_resp;

    if (TIMEOUT < 18) begin : g_timeout_check
        $error("TIMEOUT must be at least 18");
    end

    // A port stops being "in service" once its done pulse is out (GAP), so a
    // request arriving together with done is accepted.
    assign w_serving  = (r_state == ISSUE) || (r_state == WAIT);
    assign w_cap0     = req0 && !r_pend[0] && !(w_serving && !r_owner);
    assign w_cap1     = req1 && !r_pend[1] && !(w_serving && r_owner);
    assign w_grant_en = (r_state == IDLE) && (r_pend != 2'b00);
    assign w_grant    = (r_pend == 2'b11) ? !r_last : r_pend[1];
    assign w_fin      = (r_state == WAIT) && (map_done || w_tout);
    assign w_resp     = map_done ? map_resp : '0;

`ifdef PUF_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    assign w_tout = (r_state == WAIT) && !map_done && (r_cnt == CW'(TIMEOUT - 1));

    // Counts WAIT cycles; cleared while issuing so each WAIT starts at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (r_state == ISSUE)
            r_cnt <= '0;
        else if (r_state == WAIT)
            r_cnt <= r_cnt + CW'(1);
    end
`else
    assign w_tout = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_grant_en ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = w_fin ? GAP : WAIT;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Challenge capture, pending flags and round-robin grant bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend     <= 2'b00;
            r_hold0    <= '0;
            r_hold1    <= '0;
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_map_data <= '0;
        end else begin
            if (w_cap0)
                r_hold0 <= chal0;
            if (w_cap1)
                r_hold1 <= chal1;
            r_pend[0] <= w_cap0 || (r_pend[0] && !(w_grant_en && !w_grant));
            r_pend[1] <= w_cap1 || (r_pend[1] && !(w_grant_en && w_grant));
            if (w_grant_en) begin
                r_owner    <= w_grant;
                r_last     <= w_grant;
                r_map_data <= w_grant ? r_hold1 : r_hold0;
            end
        end
    end

    // Completion: latch response for the owner and emit one-cycle done/err pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_resp0 <= '0;
            r_resp1 <= '0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
        end else begin
            r_done0 <= w_fin && !r_owner;
            r_done1 <= w_fin && r_owner;
            r_err0  <= w_tout && !r_owner;
            r_err1  <= w_tout && r_owner;
            if (w_fin && !r_owner)
                r_resp0 <= w_resp;
            if (w_fin && r_owner)
                r_resp1 <= w_resp;
        end
    end

    assign busy0       = r_pend[0] || ((r_state != IDLE) && !r_owner);
    assign busy1       = r_pend[1] || ((r_state != IDLE) && r_owner);
    assign done0       = r_done0;
    assign done1       = r_done1;
    assign resp0       = r_resp0;
    assign resp1       = r_resp1;
    assign err0        = r_err0;
    assign err1        = r_err1;
    assign map_trigger = (r_state == ISSUE);
    assign map_data    = r_map_data;
endmodule

// File: tb/tb_puf_dual_arbiter.sv
// tb_puf_dual_arbiter: self-checking bench with an engine model, directed tables and a random scoreboard.
module tb_puf_dual_arbiter;
    localparam int IW = 128;
    localparam int OW = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [IW-1:0] chal0 = '0, chal1 = '0;
    logic          busy0, busy1, done0, done1, err0, err1, map_trigger;
    logic [OW-1:0] resp0, resp1;
    logic [IW-1:0] map_data;
    logic          map_done = 1'b0;
    logic [OW-1:0] map_resp = '0;

    puf_dual_arbiter #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .chal0(chal0), .chal1(chal1),
        .busy0(busy0), .busy1(busy1), .done0(done0), .done1(done1), .resp0(resp0), .resp1(resp1),
        .err0(err0), .err1(err1), .map_trigger(map_trigger), .map_data(map_data),
        .map_done(map_done), .map_resp(map_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int eng_lat = 16;
    bit eng_en = 1'b1;
    int inj_req = 0;
    int inj_ack = 0;

    typedef struct {
        bit            port;
        logic [IW-1:0] chal;
        int            lat;
        logic [OW-1:0] exp_resp;
    } vec_t;

    function automatic logic [OW-1:0] eng_f(input logic [IW-1:0] c);
        return c[OW-1:0] ^ 16'hACDB;
    endfunction

    task automatic chk(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Mapping engine: answers eng_lat cycles after a trigger, aborts on reset,
    // and can emit one unsolicited done pulse on request
    initial begin
        int            cnt;
        logic [IW-1:0] d;
        cnt = 0;
        d = '0;
        forever begin
            @(negedge clk);
            map_done = 1'b0;
            if (!reset)
                cnt = 0;
            else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    map_done = 1'b1;
                    map_resp = eng_f(d);
                end
            end else if (map_trigger && eng_en) begin
                d = map_data;
                cnt = eng_lat;
            end
            if (inj_req != inj_ack) begin
                inj_ack = inj_req;
                map_done = 1'b1;
                map_resp = 16'h7777;
            end
        end
    end

    task automatic pulse(input bit p, input logic [IW-1:0] c);
        if (p) begin
            req1 = 1'b1;
            chal1 = c;
        end else begin
            req0 = 1'b1;
            chal0 = c;
        end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic wait_trig(output int n);
        n = 0;
        while (!map_trigger && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!map_trigger) begin
            checks++;
            errors++;
            $display("FAIL wait_trig: no map_trigger within %0d cycles", n);
        end
    endtask

    task automatic wait_done(output int n, output int p);
        n = 0;
        while (!done0 && !done1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        p = done1 ? 1 : (done0 ? 0 : -1);
        if (p < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no done pulse within %0d cycles", n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy0 || busy1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chki("drain_idle", int'(busy0 || busy1), 0);
    endtask

    initial begin
        vec_t          tbl[5];
        int            n, p, prev, c0, c1, tr, e;
        bit            out[2];
        logic [IW-1:0] ex[2];
        bit            r;

        tbl[0] = '{1'b0, 128'h1234, 16, 16'hBEEF};
        tbl[1] = '{1'b1, 128'h0, 5, 16'hACDB};
        tbl[2] = '{1'b0, 128'hFFFF, 1, 16'h5324};
        tbl[3] = '{1'b1, 128'hDEAD0000_0000BEEF_CAFE0000_00001111, 20, 16'hBDCA};
        tbl[4] = '{1'b0, 128'hACDB, 9, 16'h0000};

        // Reset state
        repeat (3) @(negedge clk);
        chki("rst_busy", int'({busy0, busy1}), 0);
        chki("rst_done", int'({done0, done1, err0, err1}), 0);
        chk("rst_resp", IW'({resp0, resp1}), 0);
        chki("rst_trigger", int'(map_trigger), 0);
        chk("rst_map_data", map_data, 0);
        reset = 1'b1;
        @(negedge clk);

        // Tie straight out of reset: port 0 first, then port 1
        eng_lat = 16;
        req0 = 1'b1; req1 = 1'b1; chal0 = 128'hA; chal1 = 128'hB;
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        wait_trig(n);
        chki("tie_trig_lat", n + 1, 2);
        chk("tie_first_data", map_data, 128'hA);
        wait_done(n, p);
        chki("tie_first_port", p, 0);
        chk("tie_resp0", IW'(resp0), IW'(eng_f(128'hA)));
        wait_trig(n);
        chki("tie_trig_after_done", n, 2);
        chk("tie_second_data", map_data, 128'hB);
        wait_done(n, p);
        chki("tie_second_port", p, 1);
        chk("tie_resp1", IW'(resp1), IW'(eng_f(128'hB)));
        @(negedge clk);
        chki("tie_idle_busy", int'({busy0, busy1}), 0);

        // Single-request table
        foreach (tbl[i]) begin
            @(negedge clk);
            eng_lat = tbl[i].lat;
            pulse(tbl[i].port, tbl[i].chal);
            wait_trig(n);
            chki("tbl_trig_lat", n + 1, 2);
            chk("tbl_map_data", map_data, tbl[i].chal);
            @(negedge clk);
            chki("tbl_trig_one_cycle", int'(map_trigger), 0);
            wait_done(n, p);
            chki("tbl_done_port", p, int'(tbl[i].port));
            chki("tbl_done_lat", n + 1, tbl[i].lat + 1);
            chk("tbl_resp", IW'(tbl[i].port ? resp1 : resp0), IW'(tbl[i].exp_resp));
            @(negedge clk);
            chki("tbl_busy_after", int'(tbl[i].port ? busy1 : busy0), 0);
            chki("tbl_done_pulse", int'(done0 || done1), 0);
            chk("tbl_map_data_held", map_data, tbl[i].chal);
        end

        // Fairness with both requesters continuously asking
        eng_lat = 5;
        req0 = 1'b1; req1 = 1'b1; chal0 = 128'h100; chal1 = 128'h200;
        prev = -1;
        for (int k = 0; k < 8; k++) begin
            wait_done(n, p);
            if (k > 0)
                chki("fair_alternate", int'(p != prev), 1);
            chk("fair_resp", IW'(p == 1 ? resp1 : resp0), IW'(eng_f(p == 1 ? 128'h200 : 128'h100)));
            prev = p;
            @(negedge clk);
        end
        req0 = 1'b0; req1 = 1'b0;
        drain();

        // Duplicate request while busy is ignored
        eng_lat = 20;
        @(negedge clk);
        pulse(1'b1, 128'h55);
        wait_trig(n);
        repeat (3) @(negedge clk);
        pulse(1'b1, 128'h66);
        c0 = 0; c1 = 0; tr = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done1) begin
                c1++;
                chk("dup_resp", IW'(resp1), IW'(eng_f(128'h55)));
            end
            if (done0) c0++;
            if (map_trigger) tr++;
        end
        chki("dup_done1_count", c1, 1);
        chki("dup_done0_count", c0, 0);
        chki("dup_no_retrigger", tr, 0);
        chki("dup_busy1", int'(busy1), 0);

        // Reset during WAIT
        eng_lat = 30;
        pulse(1'b0, 128'h77);
        wait_trig(n);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chki("mid_rst_busy", int'({busy0, busy1}), 0);
        chki("mid_rst_trigger", int'(map_trigger), 0);
        chk("mid_rst_map_data", map_data, 0);
        chk("mid_rst_resp", IW'({resp0, resp1}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        inj_req++;
        c0 = 0;
        repeat (6) begin
            @(negedge clk);
            if (done0 || done1 || map_trigger) c0++;
        end
        chki("stale_done_ignored", c0, 0);
        eng_lat = 8;
        pulse(1'b1, 128'h99);
        wait_trig(n);
        chk("post_rst_data", map_data, 128'h99);
        wait_done(n, p);
        chki("post_rst_port", p, 1);
        chk("post_rst_resp", IW'(resp1), IW'(eng_f(128'h99)));
        drain();

        // Random traffic against a scoreboard of outstanding requests per port
        out[0] = 1'b0; out[1] = 1'b0;
        ex[0] = '0; ex[1] = '0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done0) begin
                chki("rand_done0_expected", int'(out[0]), 1);
                chk("rand_resp0", IW'(resp0), IW'(eng_f(ex[0])));
                out[0] = 1'b0;
            end
            if (done1) begin
                chki("rand_done1_expected", int'(out[1]), 1);
                chk("rand_resp1", IW'(resp1), IW'(eng_f(ex[1])));
                out[1] = 1'b0;
            end
            chki("rand_busy0", int'(busy0), int'(out[0] || done0));
            chki("rand_busy1", int'(busy1), int'(out[1] || done1));
            if (map_trigger)
                chki("rand_map_data", int'((out[0] && map_data == ex[0]) || (out[1] && map_data == ex[1])), 1);
            eng_lat = $urandom_range(1, 20);
            r = (i < 450) && ($urandom_range(0, 3) == 0);
            req0 = r;
            chal0 = {$urandom, $urandom, $urandom, $urandom};
            if (r && !out[0]) begin
                out[0] = 1'b1;
                ex[0] = chal0;
            end
            r = (i < 450) && ($urandom_range(0, 3) == 0);
            req1 = r;
            chal1 = {$urandom, $urandom, $urandom, $urandom};
            if (r && !out[1]) begin
                out[1] = 1'b1;
                ex[1] = chal1;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chki("rand_all_served", int'({out[0], out[1]}), 0);
        drain();

`ifdef PUF_ARB_TIMEOUT_EN
        // Engine never answers: abort after TIMEOUT WAIT cycles, then serve port 1
        eng_en = 1'b0;
        pulse(1'b0, 128'hC0);
        wait_trig(n);
        pulse(1'b1, 128'hC1);
        wait_done(n, p);
        chki("to_port", p, 0);
        chki("to_lat", n + 1, TO + 1);
        chki("to_err0", int'(err0), 1);
        chk("to_resp0", IW'(resp0), 0);
        eng_en = 1'b1;
        eng_lat = 6;
        @(negedge clk);
        chki("to_err_pulse", int'(err0), 0);
        wait_trig(n);
        chk("to_next_data", map_data, 128'hC1);
        wait_done(n, p);
        chki("to_next_port", p, 1);
        chki("to_next_err", int'(err1), 0);
        chk("to_next_resp", IW'(resp1), IW'(eng_f(128'hC1)));
`else
        // Without the timeout the arbiter waits indefinitely
        eng_en = 1'b0;
        pulse(1'b0, 128'hC0);
        wait_trig(n);
        e = 0; c0 = 0;
        repeat (TO + 40) begin
            @(negedge clk);
            if (err0) e++;
            if (done0) c0++;
        end
        chki("no_to_err0", e, 0);
        chki("no_to_done0", c0, 0);
        chki("no_to_busy0", int'(busy0), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
